ctrl_pipeline: RTL and testbench

- Consumer end of the 18-bit decoded control word: carries it from ID through the EX, MEM and WB pipeline registers of the 5-stage MIPS core.
- Stores per stage the destination register and the EX-stage source registers.
- Generates the load-use stall, bubble insertion and flush handling.
- Produces operand-forwarding selects for the EX-stage ALU.

---
 rtl/mips_ctrl_pkg.sv | 34 +++
 rtl/hazard_detect.sv | 69 ++++++
 rtl/ctrl_pipeline.sv | 105 ++++++++++
 tb/tb_ctrl_pipeline.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared control-word bit map, forwarding select encodings and pipeline constants
// for the MIPS control pipeline.
package mips_ctrl_pkg;

    localparam int unsigned CONTROL_SIZE = 18;
    localparam int unsigned REG_ADDR_W   = 5;
    localparam int unsigned LINK_REG     = 31;

    localparam int unsigned REG_WRITE = 0;
    localparam int unsigned BRANCH    = 1;
    localparam int unsigned UNSIGNED  = 2;
    localparam int unsigned MEM_READ  = 3;
    localparam int unsigned MEM_WRITE = 4;
    localparam int unsigned MASK_1    = 5;
    localparam int unsigned MASK_2    = 6;
    localparam int unsigned REG_DST   = 7;
    localparam int unsigned SHIFT_SRC = 8;
    localparam int unsigned ALU_SRC   = 9;
    localparam int unsigned ALU_OP0   = 10;
    localparam int unsigned ALU_OP1   = 11;
    localparam int unsigned ALU_OP2   = 12;
    localparam int unsigned MEM_2_REG = 13;
    localparam int unsigned J_RET_DST = 14;
    localparam int unsigned EQORNE    = 15;
    localparam int unsigned JUMP_SRC  = 16;
    localparam int unsigned JUMP_B    = 17;

    typedef enum logic [1:0] {
        FWD_NONE = 2'b00,
        FWD_MEM  = 2'b01,
        FWD_WB   = 2'b10
    } fwd_sel_e;

endpackage

// File: rtl/hazard_detect.sv
// Combinational stall and operand-forwarding logic for the EX stage.
// CTRL_PIPE_FORWARDING_EN enables forwarding; otherwise every RAW hazard stalls.
module hazard_detect
    import mips_ctrl_pkg::*;
#(
    parameter int unsigned REG_ADDR_W = 5
) (
    input  logic                  i_ex_reg_write,
    input  logic                  i_ex_mem_read,
    input  logic [REG_ADDR_W-1:0] i_ex_dst,
    input  logic [REG_ADDR_W-1:0] i_ex_rs,
    input  logic [REG_ADDR_W-1:0] i_ex_rt,
    input  logic                  i_mem_reg_write,
    input  logic [REG_ADDR_W-1:0] i_mem_dst,
    input  logic                  i_wb_reg_write,
    input  logic [REG_ADDR_W-1:0] i_wb_dst,
    input  logic [REG_ADDR_W-1:0] i_id_rs,
    input  logic [REG_ADDR_W-1:0] i_id_rt,
    input  logic                  i_flush,
    output logic                  o_stall,
    output logic [1:0]            o_fwd_a,
    output logic [1:0]            o_fwd_b
);

    logic w_ex_wr;
    logic w_mem_wr;
    logic w_wb_wr;
    logic w_ex_match;
    logic w_hazard;

    // Register 0 is hardwired, so a write to it never creates a dependency.
    assign w_ex_wr    = i_ex_reg_write  && (i_ex_dst  != '0);
    assign w_mem_wr   = i_mem_reg_write && (i_mem_dst != '0);
    assign w_wb_wr    = i_wb_reg_write  && (i_wb_dst  != '0);
    assign w_ex_match = w_ex_wr && ((i_ex_dst == i_id_rs) || (i_ex_dst == i_id_rt));

`ifdef CTRL_PIPE_FORWARDING_EN
    assign w_hazard = w_ex_match && i_ex_mem_read;

    always_comb begin
        o_fwd_a = FWD_NONE;
        o_fwd_b = FWD_NONE;
        if (w_mem_wr && (i_mem_dst == i_ex_rs)) begin
            o_fwd_a = FWD_MEM;
        end else if (w_wb_wr && (i_wb_dst == i_ex_rs)) begin
            o_fwd_a = FWD_WB;
        end
        if (w_mem_wr && (i_mem_dst == i_ex_rt)) begin
            o_fwd_b = FWD_MEM;
        end else if (w_wb_wr && (i_wb_dst == i_ex_rt)) begin
            o_fwd_b = FWD_WB;
        end
    end
`else
    logic w_mem_match;
    logic w_unused;

    // WB is safe: the register file writes before it reads.
    assign w_mem_match = w_mem_wr && ((i_mem_dst == i_id_rs) || (i_mem_dst == i_id_rt));
    assign w_hazard    = w_ex_match || w_mem_match;
    assign o_fwd_a     = FWD_NONE;
    assign o_fwd_b     = FWD_NONE;
    assign w_unused    = ^{i_ex_mem_read, i_ex_rs, i_ex_rt, w_wb_wr};
`endif

    // A flushed instruction is discarded, so it has nothing to wait for.
    assign o_stall = w_hazard && !i_flush;

endmodule

// File: rtl/ctrl_pipeline.sv
// Carries the decoded control word, destination and EX sources through EX/MEM/WB,
// inserting bubbles on stall or flush. Forwarding gated by CTRL_PIPE_FORWARDING_EN.
module ctrl_pipeline
    import mips_ctrl_pkg::*;
#(
    parameter int unsigned CONTROL_SIZE = mips_ctrl_pkg::CONTROL_SIZE,
    parameter int unsigned REG_ADDR_W   = mips_ctrl_pkg::REG_ADDR_W,
    parameter int unsigned LINK_REG     = mips_ctrl_pkg::LINK_REG
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_enable,
    input  logic [CONTROL_SIZE-1:0] i_ctrl,
    input  logic [REG_ADDR_W-1:0]   i_rs,
    input  logic [REG_ADDR_W-1:0]   i_rt,
    input  logic [REG_ADDR_W-1:0]   i_rd,
    input  logic                    i_flush,
    output logic                    o_stall,
    output logic [CONTROL_SIZE-1:0] o_ex_ctrl,
    output logic [CONTROL_SIZE-1:0] o_mem_ctrl,
    output logic [CONTROL_SIZE-1:0] o_wb_ctrl,
    output logic [REG_ADDR_W-1:0]   o_ex_dst,
    output logic [REG_ADDR_W-1:0]   o_mem_dst,
    output logic [REG_ADDR_W-1:0]   o_wb_dst,
    output logic [1:0]              o_fwd_a,
    output logic [1:0]              o_fwd_b
);

    logic [CONTROL_SIZE-1:0] r_ex_ctrl, r_mem_ctrl, r_wb_ctrl;
    logic [REG_ADDR_W-1:0]   r_ex_dst, r_mem_dst, r_wb_dst;
    logic [REG_ADDR_W-1:0]   r_ex_rs, r_ex_rt;

    logic [REG_ADDR_W-1:0]   w_id_dst;
    logic                    w_bubble;
    logic                    w_stall;

    always_comb begin
        w_id_dst = i_rt;
        if (i_ctrl[J_RET_DST]) begin
            w_id_dst = REG_ADDR_W'(LINK_REG);
        end else if (i_ctrl[REG_DST]) begin
            w_id_dst = i_rd;
        end
    end

    assign w_bubble = i_flush || w_stall;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ex_ctrl  <= '0;
            r_mem_ctrl <= '0;
            r_wb_ctrl  <= '0;
            r_ex_dst   <= '0;
            r_mem_dst  <= '0;
            r_wb_dst   <= '0;
            r_ex_rs    <= '0;
            r_ex_rt    <= '0;
        end else if (i_enable) begin
            r_wb_ctrl  <= r_mem_ctrl;
            r_wb_dst   <= r_mem_dst;
            r_mem_ctrl <= r_ex_ctrl;
            r_mem_dst  <= r_ex_dst;
            if (w_bubble) begin
                r_ex_ctrl <= '0;
                r_ex_dst  <= '0;
                r_ex_rs   <= '0;
                r_ex_rt   <= '0;
            end else begin
                r_ex_ctrl <= i_ctrl;
                r_ex_dst  <= w_id_dst;
                r_ex_rs   <= i_rs;
                r_ex_rt   <= i_rt;
            end
        end
    end

    hazard_detect #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_hazard_detect (
        .i_ex_reg_write  (r_ex_ctrl[REG_WRITE]),
        .i_ex_mem_read   (r_ex_ctrl[MEM_READ]),
        .i_ex_dst        (r_ex_dst),
        .i_ex_rs         (r_ex_rs),
        .i_ex_rt         (r_ex_rt),
        .i_mem_reg_write (r_mem_ctrl[REG_WRITE]),
        .i_mem_dst       (r_mem_dst),
        .i_wb_reg_write  (r_wb_ctrl[REG_WRITE]),
        .i_wb_dst        (r_wb_dst),
        .i_id_rs         (i_rs),
        .i_id_rt         (i_rt),
        .i_flush         (i_flush),
        .o_stall         (w_stall),
        .o_fwd_a         (o_fwd_a),
        .o_fwd_b         (o_fwd_b)
    );

    assign o_stall    = w_stall;
    assign o_ex_ctrl  = r_ex_ctrl;
    assign o_mem_ctrl = r_mem_ctrl;
    assign o_wb_ctrl  = r_wb_ctrl;
    assign o_ex_dst   = r_ex_dst;
    assign o_mem_dst  = r_mem_dst;
    assign o_wb_dst   = r_wb_dst;

endmodule

// File: tb/tb_ctrl_pipeline.sv
// Self-checking bench for ctrl_pipeline: directed scenarios plus random traffic
// against an instruction-level model; follows CTRL_PIPE_FORWARDING_EN like the RTL.
module tb_ctrl_pipeline;

    localparam logic [17:0] ADDU  = 18'h00081;  // REG_WRITE | REG_DST
    localparam logic [17:0] ADDU2 = 18'h07601;  // includes J_RET_DST
    localparam logic [17:0] LW    = 18'h02009;  // REG_WRITE | MEM_READ | MEM_2_REG
    localparam logic [17:0] JAL   = 18'h04001;  // REG_WRITE | J_RET_DST

    typedef struct packed {
        logic [17:0] ctrl;
        logic [4:0]  dst;
        logic [4:0]  rs;
        logic [4:0]  rt;
    } instr_t;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic [17:0] ctrl;
    logic [4:0]  rs, rt, rd;
    logic        flush;
    logic        o_stall;
    logic [17:0] o_ex_ctrl, o_mem_ctrl, o_wb_ctrl;
    logic [4:0]  o_ex_dst, o_mem_dst, o_wb_dst;
    logic [1:0]  o_fwd_a, o_fwd_b;

    int          n_checks = 0;
    int          n_errors = 0;
    instr_t      m_ex, m_mem, m_wb;
    logic        obs_stall;
    logic [1:0]  obs_fwd_a, obs_fwd_b;

    ctrl_pipeline u_dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_enable   (enable),
        .i_ctrl     (ctrl),
        .i_rs       (rs),
        .i_rt       (rt),
        .i_rd       (rd),
        .i_flush    (flush),
        .o_stall    (o_stall),
        .o_ex_ctrl  (o_ex_ctrl),
        .o_mem_ctrl (o_mem_ctrl),
        .o_wb_ctrl  (o_wb_ctrl),
        .o_ex_dst   (o_ex_dst),
        .o_mem_dst  (o_mem_dst),
        .o_wb_dst   (o_wb_dst),
        .o_fwd_a    (o_fwd_a),
        .o_fwd_b    (o_fwd_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [4:0] id_dst(input logic [17:0] c, input logic [4:0] d_rd,
                                          input logic [4:0] d_rt);
        if (c[14]) return 5'd31;
        if (c[7])  return d_rd;
        return d_rt;
    endfunction

    // True when an instruction will write a real register equal to r.
    function automatic bit writes_to(input instr_t e, input logic [4:0] r);
        return e.ctrl[0] && (r != 5'd0) && (e.dst == r);
    endfunction

    function automatic bit model_stall(input logic [4:0] a, input logic [4:0] b, input bit fl);
        bit hz;
`ifdef CTRL_PIPE_FORWARDING_EN
        hz = m_ex.ctrl[3] && (writes_to(m_ex, a) || writes_to(m_ex, b));
`else
        hz = writes_to(m_ex, a) || writes_to(m_ex, b) || writes_to(m_mem, a) || writes_to(m_mem, b);
`endif
        return hz && !fl;
    endfunction

    function automatic logic [1:0] model_fwd(input logic [4:0] src);
`ifdef CTRL_PIPE_FORWARDING_EN
        if (writes_to(m_mem, src)) return 2'b01;
        if (writes_to(m_wb, src))  return 2'b10;
`endif
        return 2'b00;
    endfunction

    task automatic check_model(input bit exp_stall);
        check_eq("stall",    32'(o_stall),    32'(exp_stall));
        check_eq("fwd_a",    32'(o_fwd_a),    32'(model_fwd(m_ex.rs)));
        check_eq("fwd_b",    32'(o_fwd_b),    32'(model_fwd(m_ex.rt)));
        check_eq("ex_ctrl",  32'(o_ex_ctrl),  32'(m_ex.ctrl));
        check_eq("mem_ctrl", 32'(o_mem_ctrl), 32'(m_mem.ctrl));
        check_eq("wb_ctrl",  32'(o_wb_ctrl),  32'(m_wb.ctrl));
        check_eq("ex_dst",   32'(o_ex_dst),   32'(m_ex.dst));
        check_eq("mem_dst",  32'(o_mem_dst),  32'(m_mem.dst));
        check_eq("wb_dst",   32'(o_wb_dst),   32'(m_wb.dst));
    endtask

    // One ID issue slot: drive, check just after the falling edge, then advance the model.
    task automatic cycle(input logic [17:0] c, input logic [4:0] a, input logic [4:0] b,
                         input logic [4:0] d, input bit fl, input bit en);
        bit     es;
        instr_t nxt;
        ctrl = c; rs = a; rt = b; rd = d; flush = fl; enable = en;
        #1;
        es = model_stall(a, b, fl);
        check_model(es);
        obs_stall = o_stall;
        obs_fwd_a = o_fwd_a;
        obs_fwd_b = o_fwd_b;
        @(posedge clk);
        if (en) begin
            nxt   = (fl || es) ? '0 : '{ctrl: c, dst: id_dst(c, d, b), rs: a, rt: b};
            m_wb  = m_mem;
            m_mem = m_ex;
            m_ex  = nxt;
        end
        @(negedge clk);
    endtask

    task automatic nop();
        cycle(18'h0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
    endtask

    task automatic reset_now(input string tag);
        rst_n = 1'b0;
        #1;
        check_eq({tag, "_ex_ctrl"},  32'(o_ex_ctrl),  32'h0);
        check_eq({tag, "_mem_ctrl"}, 32'(o_mem_ctrl), 32'h0);
        check_eq({tag, "_wb_ctrl"},  32'(o_wb_ctrl),  32'h0);
        check_eq({tag, "_dsts"},     32'({o_ex_dst, o_mem_dst, o_wb_dst}), 32'h0);
        check_eq({tag, "_stall"},    32'(o_stall),    32'h0);
        check_eq({tag, "_fwd"},      32'({o_fwd_a, o_fwd_b}), 32'h0);
        m_ex = '0; m_mem = '0; m_wb = '0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int stall_cycles;
        int exp_stall_cycles;
        rst_n = 1'b0; enable = 1'b1; ctrl = '0; rs = '0; rt = '0; rd = '0; flush = 1'b0;
        m_ex = '0; m_mem = '0; m_wb = '0;
        @(negedge clk);
        reset_now("rst");

        // Plain ALU op walks EX -> MEM -> WB in three cycles.
        cycle(ADDU, 5'd1, 5'd2, 5'd5, 1'b0, 1'b1);
        check_eq("addu_ex_dst", 32'(o_ex_dst), 32'd5);
        nop(); nop();
        check_eq("addu_wb_ctrl", 32'(o_wb_ctrl), 32'(ADDU));
        check_eq("addu_wb_dst",  32'(o_wb_dst),  32'd5);
        cycle(ADDU2, 5'd1, 5'd2, 5'd5, 1'b0, 1'b1);
        nop(); nop();
        check_eq("addu2_wb_ctrl", 32'(o_wb_ctrl), 32'(ADDU2));
        check_eq("addu2_wb_dst",  32'(o_wb_dst),  32'd31);

        // Load-use: count stall cycles, bounded.
        cycle(LW, 5'd0, 5'd8, 5'd0, 1'b0, 1'b1);
        stall_cycles = 0;
        for (int i = 0; i < 5; i++) begin
            cycle(ADDU, 5'd8, 5'd9, 5'd10, 1'b0, 1'b1);
            if (i == 0) check_eq("lu_bubble", 32'(o_ex_ctrl), 32'h0);
            if (!obs_stall) break;
            stall_cycles++;
        end
`ifdef CTRL_PIPE_FORWARDING_EN
        exp_stall_cycles = 1;
`else
        exp_stall_cycles = 2;
`endif
        check_eq("lu_stall_cycles", 32'(stall_cycles), 32'(exp_stall_cycles));
        nop();
`ifdef CTRL_PIPE_FORWARDING_EN
        check_eq("lu_fwd_a", 32'(obs_fwd_a), 32'd2);
`else
        check_eq("lu_fwd_a", 32'(obs_fwd_a), 32'd0);
`endif
        nop(); nop();

        // Producer then consumer at distance 2 and 1.
        cycle(ADDU, 5'd1, 5'd2, 5'd3, 1'b0, 1'b1);
        nop();
        cycle(ADDU, 5'd4, 5'd3, 5'd6, 1'b0, 1'b1);
        nop();
`ifdef CTRL_PIPE_FORWARDING_EN
        check_eq("fwd_b_wb", 32'(obs_fwd_b), 32'd2);
`endif
        nop(); nop();
        cycle(ADDU, 5'd1, 5'd2, 5'd3, 1'b0, 1'b1);
        cycle(ADDU, 5'd4, 5'd3, 5'd6, 1'b0, 1'b1);
`ifdef CTRL_PIPE_FORWARDING_EN
        nop();
        check_eq("fwd_b_mem", 32'(obs_fwd_b), 32'd1);
`endif
        nop(); nop(); nop();

        // Register 0 never creates a dependency.
        cycle(ADDU, 5'd1, 5'd2, 5'd0, 1'b0, 1'b1);
        cycle(ADDU, 5'd0, 5'd0, 5'd7, 1'b0, 1'b1);
        check_eq("r0_stall", 32'(obs_stall), 32'd0);
        nop();
        check_eq("r0_fwd_a", 32'(obs_fwd_a), 32'd0);

        // Flush masks a load-use stall and still inserts a bubble.
        cycle(LW, 5'd0, 5'd7, 5'd0, 1'b0, 1'b1);
        cycle(ADDU, 5'd7, 5'd1, 5'd9, 1'b1, 1'b1);
        check_eq("flush_stall", 32'(obs_stall), 32'd0);
        check_eq("flush_bubble", 32'(o_ex_ctrl), 32'h0);
        cycle(JAL, 5'd0, 5'd0, 5'd4, 1'b0, 1'b1);
        check_eq("jal_dst", 32'(o_ex_dst), 32'd31);

        // Freeze for four cycles, then reset mid-stream.
        cycle(ADDU, 5'd2, 5'd3, 5'd12, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) cycle(ADDU, 5'd12, 5'd1, 5'd13, 1'b0, 1'b0);
        cycle(ADDU, 5'd5, 5'd6, 5'd14, 1'b0, 1'b1);
        reset_now("midrst");

        // Random traffic on a small register window to provoke hazards.
        for (int i = 0; i < 400; i++) begin
            logic [17:0] c;
            c    = 18'($urandom);
            c[0] = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 63) == 0) begin
                reset_now("rndrst");
            end else begin
                cycle(c, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                      5'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0),
                      ($urandom_range(0, 7) != 0));
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
